// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg: shared control typedefs for the pipeline hazard logic
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_ERROR = 2'b10
    } mem_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_t;

endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline <-> hazard controller signal bundle
interface hazard_controller_if #(parameter int CNT_WIDTH = 32);
    logic [4:0]           iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iRdM, iRdW;
    logic                 iLoadE, iPCSrcE, iRegWriteM, iRegWriteW, iMemReqM, iMemReadyM;
    logic                 oStallF, oStallD, oStallE, oStallM;
    logic                 oFlushD, oFlushE, oFlushW;
    logic [1:0]           oForwardAE, oForwardBE;
    logic                 oMemTimeout;
    logic [CNT_WIDTH-1:0] oStallCount;

    modport master (
        output iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iRdM, iRdW,
        output iLoadE, iPCSrcE, iRegWriteM, iRegWriteW, iMemReqM, iMemReadyM,
        input  oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oFlushW,
        input  oForwardAE, oForwardBE, oMemTimeout, oStallCount
    );

    modport slave (
        input  iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iRdM, iRdW,
        input  iLoadE, iPCSrcE, iRegWriteM, iRegWriteW, iMemReqM, iMemReadyM,
        output oStallF, oStallD, oStallE, oStallM, oFlushD, oFlushE, oFlushW,
        output oForwardAE, oForwardBE, oMemTimeout, oStallCount
    );
endinterface

// File: rtl/hazard_controller_forward_select.sv
// forward_select: picks the bypass source for one Execute operand, Memory first
module forward_select
    import hazard_controller_pkg::*;
(
    input  logic [4:0] iRs,
    input  logic [4:0] iRdM,
    input  logic       iRegWriteM,
    input  logic [4:0] iRdW,
    input  logic       iRegWriteW,
    output fwd_t       oFwd
);
    logic w_hit_m, w_hit_w;

    assign w_hit_m = iRegWriteM && (iRdM != 5'd0) && (iRdM == iRs);
    assign w_hit_w = iRegWriteW && (iRdW != 5'd0) && (iRdW == iRs);
    assign oFwd    = w_hit_m ? FWD_MEM : w_hit_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush/forward control with memory-wait FSM and stall counter
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    hazard_controller_if.slave hz
);
    localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1;

    mem_state_t           r_state, w_state_nxt;
    logic [WCW-1:0]       r_wait_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic                 w_memstall, w_timeout, w_load_use, w_lu_stall, w_stall_f;
    fwd_t                 w_fwd_a, w_fwd_b;

    forward_select u_fwd_a (
        .iRs        (hz.iRs1E),
        .iRdM       (hz.iRdM),
        .iRegWriteM (hz.iRegWriteM),
        .iRdW       (hz.iRdW),
        .iRegWriteW (hz.iRegWriteW),
        .oFwd       (w_fwd_a)
    );

    forward_select u_fwd_b (
        .iRs        (hz.iRs2E),
        .iRdM       (hz.iRdM),
        .iRegWriteM (hz.iRegWriteM),
        .iRdW       (hz.iRdW),
        .iRegWriteW (hz.iRegWriteW),
        .oFwd       (w_fwd_b)
    );

    // FSM state register; reset is asynchronous so WAIT/ERROR clear immediately
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM next state: zero-wait accesses stay in IDLE, ERROR is absorbing
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = (hz.iMemReqM && !hz.iMemReadyM) ? S_WAIT : S_IDLE;
            S_WAIT:  w_state_nxt = hz.iMemReadyM ? S_IDLE :
                                   (r_wait_cnt == WCW'(TIMEOUT_CYCLES - 1)) ? S_ERROR : S_WAIT;
            default: w_state_nxt = S_ERROR;
        endcase
    end

    // FSM outputs: memory stall and timeout flag
    always_comb begin
        w_memstall = ((r_state == S_IDLE) && hz.iMemReqM && !hz.iMemReadyM) ||
                     ((r_state == S_WAIT) && !hz.iMemReadyM) ||
                     (r_state == S_ERROR);
        w_timeout  = (r_state == S_ERROR);
    end

    // Wait counter: zero outside WAIT so it starts at 0 on every entry
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) r_wait_cnt <= '0;
        else      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
    end

    // A taken branch discards the Decode instruction, so it overrides the load-use stall
    assign w_load_use = hz.iLoadE && (hz.iRdE != 5'd0) &&
                        ((hz.iRdE == hz.iRs1D) || (hz.iRdE == hz.iRs2D));
    assign w_lu_stall = w_load_use && !hz.iPCSrcE;
    assign w_stall_f  = w_memstall || w_lu_stall;

    // Stall-cycle counter, saturating at all-ones
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)                            r_stall_cnt <= '0;
        else if (w_stall_f && ~&r_stall_cnt) r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    // Memory stall freezes everything and holds back flushes until it drops
    assign hz.oStallF     = w_stall_f;
    assign hz.oStallD     = w_stall_f;
    assign hz.oStallE     = w_memstall;
    assign hz.oStallM     = w_memstall;
    assign hz.oFlushW     = w_memstall;
    assign hz.oFlushD     = !w_memstall && hz.iPCSrcE;
    assign hz.oFlushE     = !w_memstall && (hz.iPCSrcE || w_load_use);
    assign hz.oForwardAE  = w_fwd_a;
    assign hz.oForwardBE  = w_fwd_b;
    assign hz.oMemTimeout = w_timeout;
    assign hz.oStallCount = r_stall_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scoreboard bench for hazard_controller
module tb_hazard_controller;
    localparam int CW = 4;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    logic   iClk = 1'b0;
    logic   iRst = 1'b1;
    exp_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    logic [CW-1:0] exp_cnt = '0;

    hazard_controller_if #(.CNT_WIDTH(CW)) hz ();

    hazard_controller #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(CW)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .hz   (hz.slave)
    );

    always #5 iClk = ~iClk;

    task automatic clear_inputs();
        hz.iRs1D = 0; hz.iRs2D = 0; hz.iRs1E = 0; hz.iRs2E = 0;
        hz.iRdE = 0; hz.iRdM = 0; hz.iRdW = 0;
        hz.iLoadE = 0; hz.iPCSrcE = 0; hz.iRegWriteM = 0; hz.iRegWriteW = 0;
        hz.iMemReqM = 0; hz.iMemReadyM = 0;
    endtask

    // sf = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    task automatic vec(input string tag, input logic [6:0] sf, input logic [1:0] fa,
                       input logic [1:0] fb, input logic to);
        exp_t e;
        exp_t got;
        logic [15:0] obs;
        e.tag = tag;
        e.val = {sf, fa, fb, to, exp_cnt};
        exp_q.push_back(e);
        #1;
        obs = {hz.oStallF, hz.oStallD, hz.oStallE, hz.oStallM, hz.oFlushD, hz.oFlushE,
               hz.oFlushW, hz.oForwardAE, hz.oForwardBE, hz.oMemTimeout, hz.oStallCount};
        got = exp_q.pop_front();
        vectors++;
        assert (obs === got.val) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.val);
        end
        if (sf[6] && !iRst && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        clear_inputs();
        @(posedge iClk);
        #1;
        vec("reset", 7'b0000000, 2'b00, 2'b00, 1'b0);
        iRst = 1'b0;
        vec("idle", 7'b0000000, 2'b00, 2'b00, 1'b0);

        hz.iRs1E = 5; hz.iRdM = 5; hz.iRegWriteM = 1; hz.iRdW = 5; hz.iRegWriteW = 1;
        vec("fwd_mem_prio", 7'b0000000, 2'b10, 2'b00, 1'b0);
        hz.iRdM = 0;
        vec("fwd_wb_rdm0", 7'b0000000, 2'b01, 2'b00, 1'b0);
        hz.iRs2E = 5; hz.iRdM = 5;
        vec("fwd_both_mem", 7'b0000000, 2'b10, 2'b10, 1'b0);
        hz.iRegWriteM = 0;
        vec("fwd_both_wb", 7'b0000000, 2'b01, 2'b01, 1'b0);
        hz.iRegWriteW = 0;
        vec("fwd_none", 7'b0000000, 2'b00, 2'b00, 1'b0);
        hz.iRs1E = 0; hz.iRs2E = 3; hz.iRdM = 0; hz.iRegWriteM = 1; hz.iRdW = 3; hz.iRegWriteW = 1;
        vec("fwd_x0_never", 7'b0000000, 2'b00, 2'b01, 1'b0);
        clear_inputs();

        hz.iLoadE = 1; hz.iRdE = 7; hz.iRs2D = 7;
        vec("load_use", 7'b1100010, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        hz.iRdM = 7; hz.iRegWriteM = 1; hz.iRs2E = 7;
        vec("load_use_after", 7'b0000000, 2'b00, 2'b10, 1'b0);
        clear_inputs();
        hz.iLoadE = 1; hz.iRdE = 0; hz.iRs1D = 0;
        vec("load_use_x0", 7'b0000000, 2'b00, 2'b00, 1'b0);
        hz.iRdE = 9; hz.iRs1D = 9;
        vec("load_use_rs1", 7'b1100010, 2'b00, 2'b00, 1'b0);
        hz.iRdE = 7; hz.iRs1D = 0; hz.iRs2D = 7; hz.iPCSrcE = 1;
        vec("load_use_branch", 7'b0000110, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        hz.iPCSrcE = 1;
        vec("branch", 7'b0000110, 2'b00, 2'b00, 1'b0);
        clear_inputs();

        hz.iMemReqM = 1;
        vec("mem_wait_0", 7'b1111001, 2'b00, 2'b00, 1'b0);
        vec("mem_wait_1", 7'b1111001, 2'b00, 2'b00, 1'b0);
        vec("mem_wait_2", 7'b1111001, 2'b00, 2'b00, 1'b0);
        hz.iMemReadyM = 1;
        vec("mem_ready", 7'b0000000, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        vec("mem_idle", 7'b0000000, 2'b00, 2'b00, 1'b0);
        hz.iMemReqM = 1; hz.iMemReadyM = 1;
        vec("mem_zero_wait", 7'b0000000, 2'b00, 2'b00, 1'b0);
        clear_inputs();
        vec("mem_zero_after", 7'b0000000, 2'b00, 2'b00, 1'b0);

        hz.iMemReqM = 1; hz.iPCSrcE = 1;
        vec("br_memstall_0", 7'b1111001, 2'b00, 2'b00, 1'b0);
        vec("br_memstall_1", 7'b1111001, 2'b00, 2'b00, 1'b0);
        hz.iMemReadyM = 1;
        vec("br_mem_release", 7'b0000110, 2'b00, 2'b00, 1'b0);
        clear_inputs();

        hz.iMemReqM = 1;
        vec("to_idle", 7'b1111001, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) vec($sformatf("to_wait_%0d", i), 7'b1111001, 2'b00, 2'b00, 1'b0);
        vec("to_error", 7'b1111001, 2'b00, 2'b00, 1'b1);
        clear_inputs();
        hz.iMemReadyM = 1; hz.iPCSrcE = 1;
        for (int i = 0; i < 8; i++) vec($sformatf("to_sticky_%0d", i), 7'b1111001, 2'b00, 2'b00, 1'b1);
        clear_inputs();

        iRst = 1'b1;
        exp_cnt = '0;
        vec("reset_async", 7'b0000000, 2'b00, 2'b00, 1'b0);
        iRst = 1'b0;
        vec("post_reset", 7'b0000000, 2'b00, 2'b00, 1'b0);
        hz.iMemReqM = 1; hz.iMemReadyM = 1;
        vec("post_reset_idle", 7'b0000000, 2'b00, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
